// File: rtl/bit_serial_alu.sv
// Bit-serial AND/OR/ADD/SUB controller: walks operands LSB first through a 1-bit
// slice with a registered carry and presents the assembled result with flags.
module bit_serial_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       operation,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b11;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] res_sh;
  logic [1:0]       op;
  logic             carry;

  logic             b_eff;
  logic             bit_out;
  logic             c_next;
  logic             arith;
  logic [WIDTH-1:0] final_res;

  function automatic logic majority(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  // One slice evaluation: SUB feeds the inverted B bit so A + ~B + 1 falls out
  always_comb begin
    arith   = op[1];
    b_eff   = b_sh[0] ^ (op == OP_SUB);
    c_next  = majority(a_sh[0], b_eff, carry);
    bit_out = a_sh[0] ^ b_eff ^ carry;
    case (op)
      OP_AND:  bit_out = a_sh[0] & b_sh[0];
      OP_OR:   bit_out = a_sh[0] | b_sh[0];
      default: bit_out = a_sh[0] ^ b_eff ^ carry;
    endcase
    final_res = {bit_out, res_sh};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      a_sh      <= '0;
      b_sh      <= '0;
      res_sh    <= '0;
      op        <= OP_AND;
      carry     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            op    <= operation;
            carry <= (operation == OP_SUB);
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= final_res[WIDTH-1:1];
          if (arith) carry <= c_next;
          if (cnt == LAST) begin
            // Flags and result commit together so no partial value is visible
            result    <= final_res;
            carry_out <= arith & c_next;
            overflow  <= arith & (carry ^ c_next);
            zero      <= (final_res == '0);
            done      <= 1'b1;
            state     <= FINISH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
